// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, filter length and parity helper.
// Used by the transmitter and the keyboard receiver.
package ps2_pkg;

   localparam int unsigned PS2_FILTER_LEN = 8;

   typedef enum logic [2:0] {
      StIdle,
      StRts,
      StStart,
      StData,
      StStop
   } ps2_state_e;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command-side bus of the PS/2 transmitter: start strobe, byte and status pulses.
interface ps2_tx_if;

   logic       wr_ps2;
   logic [7:0] din;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       tx_err;

   modport master (
      output wr_ps2, din,
      input  tx_idle, tx_done_tick, tx_err
   );

   modport slave (
      input  wr_ps2, din,
      output tx_idle, tx_done_tick, tx_err
   );

endinterface

// File: rtl/ps2_filter.sv
// PS/2 line conditioner: 2-flop synchroniser, PS2_FILTER_LEN-sample debounce and
// a one-cycle tick on a filtered high-to-low transition.
module ps2_filter
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic level,
   output logic fall_tick
);

   localparam int unsigned CntW = $clog2(PS2_FILTER_LEN);

   logic [1:0]      sync;
   logic [CntW-1:0] cnt;

   // Idle bus is high, so reset to 1 to avoid a spurious fall after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync      <= 2'b11;
         level     <= 1'b1;
         cnt       <= '0;
         fall_tick <= 1'b0;
      end else begin
         sync      <= {sync[0], line};
         fall_tick <= 1'b0;
         if (sync[1] != level) begin
            if (cnt == CntW'(PS2_FILTER_LEN - 1)) begin
               level     <= sync[1];
               cnt       <= '0;
               fall_tick <= level;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter. Define PS2_TX_TIMEOUT_EN to add a watchdog
// that aborts the frame when the device stops clocking.
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int unsigned RTS_CYCLES     = 6000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic     clk,
   input  logic     reset,
   ps2_tx_if.slave  bus,
   input  logic     ps2c,
   input  logic     ps2d,
   output logic     ps2c_oe,
   output logic     ps2d_oe
);

   localparam int unsigned RtsW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

   ps2_state_e      state;
   logic [RtsW-1:0] rts_cnt;
   logic [3:0]      n;
   logic [8:0]      shreg;
   logic            idle_q;
   logic            done_q;
   logic            err_q;
   logic            c_fall;
   logic            d_level;
   logic            unused_c_level;
   logic            unused_d_fall;

   ps2_filter u_filt_c (
      .clk       (clk),
      .reset     (reset),
      .line      (ps2c),
      .level     (unused_c_level),
      .fall_tick (c_fall)
   );

   ps2_filter u_filt_d (
      .clk       (clk),
      .reset     (reset),
      .line      (ps2d),
      .level     (d_level),
      .fall_tick (unused_d_fall)
   );

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WdW-1:0] wd;
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= StIdle;
         rts_cnt <= '0;
         n       <= '0;
         shreg   <= '0;
         ps2c_oe <= 1'b0;
         ps2d_oe <= 1'b0;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state)
            StIdle: begin
               ps2c_oe <= 1'b0;
               ps2d_oe <= 1'b0;
               idle_q  <= 1'b1;
               if (bus.wr_ps2) begin
                  shreg   <= {odd_parity(bus.din), bus.din};
                  rts_cnt <= RtsW'(RTS_CYCLES - 1);
                  ps2c_oe <= 1'b1;
                  idle_q  <= 1'b0;
                  state   <= StRts;
               end
            end
            StRts: begin
               if (rts_cnt == '0) begin
                  ps2c_oe <= 1'b0;
                  ps2d_oe <= 1'b1;
                  state   <= StStart;
`ifdef PS2_TX_TIMEOUT_EN
                  wd      <= '0;
`endif
               end else begin
                  rts_cnt <= rts_cnt - 1'b1;
               end
            end
            StStart: begin
               if (c_fall) begin
                  n       <= 4'd8;
                  ps2d_oe <= ~shreg[0];
                  state   <= StData;
               end
            end
            StData: begin
               if (c_fall) begin
                  if (n == '0) begin
                     ps2d_oe <= 1'b0;
                     state   <= StStop;
                  end else begin
                     // Outputs are registered, so drive the bit that the shift exposes.
                     shreg   <= shreg >> 1;
                     ps2d_oe <= ~shreg[1];
                     n       <= n - 1'b1;
                  end
               end
            end
            StStop: begin
               if (c_fall) begin
                  idle_q <= 1'b1;
                  state  <= StIdle;
                  if (d_level) err_q  <= 1'b1;
                  else         done_q <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         if (state == StStart || state == StData || state == StStop) begin
            if (c_fall) begin
               wd <= '0;
            end else if (wd == WdW'(TIMEOUT_CYCLES - 1)) begin
               wd      <= '0;
               ps2c_oe <= 1'b0;
               ps2d_oe <= 1'b0;
               idle_q  <= 1'b1;
               err_q   <= 1'b1;
               state   <= StIdle;
            end else begin
               wd <= wd + 1'b1;
            end
         end
`endif
      end
   end

   assign bus.tx_idle      = idle_q;
   assign bus.tx_done_tick = done_q;
   assign bus.tx_err       = err_q;

endmodule
